// File: rtl/alu_pkg.sv
// Shared types for the ALU datapath: operation codes and step-checker states.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    MUL  = 2'b10,
    PASS = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    EXP_OP = 2'b00,
    EXP_A  = 2'b01,
    EXP_C  = 2'b10
  } step_t;

endpackage

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// The product output shows the value being written this cycle, so the last iteration can be consumed on its own edge.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 CLKb,
  input  logic                 RSTb,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done     = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, mcand};
      mplier_d = mplier;
      prod_d   = '0;
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign product = prod_d;

endmodule

// File: rtl/alu_datapath.sv
// Responder for the enALU/enA/enC step sequence: op/operand registers, accumulator C,
// one-step ADD/SUB/PASS, iterative MUL with a deferred commit, and step-order policing.
//   state  | meaning
//   EXP_OP | waiting for enALU (operation select)
//   EXP_A  | waiting for enA (operand capture / start)
//   EXP_C  | waiting for enC (commit to C)
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLKb,
  input  logic             RSTb,
  input  logic             enALU,
  input  logic             enA,
  input  logic             enC,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] C_out,
  output logic             ovf,
  output logic             busy,
  output logic             seq_err,
  output logic             ovr
);

  step_t            step_q, step_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             pend_q, pend_d;
  logic             seq_err_q, seq_err_d;
  logic             ovr_q, ovr_d;

  logic               any_en, only_alu, only_a, only_c;
  logic               acc_alu, acc_a, acc_c;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     add_w, sub_w;

  assign any_en   = enALU | enA | enC;
  assign only_alu = enALU & ~enA & ~enC;
  assign only_a   = ~enALU & enA & ~enC;
  assign only_c   = ~enALU & ~enA & enC;

  assign acc_alu = only_alu && (step_q == EXP_OP);
  assign acc_a   = only_a   && (step_q == EXP_A);
  assign acc_c   = only_c   && (step_q == EXP_C);

  assign mul_start = acc_a && !mul_busy && (op_q == MUL);

  assign add_w = {1'b0, c_q} + {1'b0, a_q};
  assign sub_w = {1'b0, c_q} - {1'b0, a_q};

  shift_add_mult #(.WIDTH(WIDTH)) u_mult (
    .CLKb    (CLKb),
    .RSTb    (RSTb),
    .start   (mul_start),
    .mcand   (data_in),
    .mplier  (c_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    step_d    = step_q;
    op_d      = op_q;
    a_d       = a_q;
    c_d       = c_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q;
    seq_err_d = seq_err_q;
    ovr_d     = ovr_q;

    if (any_en && !(acc_alu || acc_a || acc_c)) seq_err_d = 1'b1;

    if (acc_alu) begin
      op_d   = op_t'(op_in);
      step_d = EXP_A;
    end

    // A dropped enA still advances the checker; ovr is the only trace of it.
    if (acc_a) begin
      step_d = EXP_C;
      if (mul_busy) ovr_d = 1'b1;
      else if (op_q != MUL) a_d = data_in;
    end

    if (acc_c) step_d = EXP_OP;

    // enC landing on the final multiply iteration commits on that same edge.
    if (mul_done && (pend_q || acc_c)) begin
      c_d    = product[WIDTH-1:0];
      ovf_d  = |product[2*WIDTH-1:WIDTH];
      pend_d = 1'b0;
    end else if (acc_c && mul_busy) begin
      pend_d = 1'b1;
    end else if (acc_c) begin
      case (op_q)
        ADD: begin
          c_d   = add_w[WIDTH-1:0];
          ovf_d = add_w[WIDTH];
        end
        SUB: begin
          c_d   = sub_w[WIDTH-1:0];
          ovf_d = sub_w[WIDTH];
        end
        MUL: begin
          c_d   = product[WIDTH-1:0];
          ovf_d = |product[2*WIDTH-1:WIDTH];
        end
        PASS: begin
          c_d   = a_q;
          ovf_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      step_q    <= EXP_OP;
      op_q      <= ADD;
      a_q       <= '0;
      c_q       <= '0;
      ovf_q     <= 1'b0;
      pend_q    <= 1'b0;
      seq_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      step_q    <= step_d;
      op_q      <= op_d;
      a_q       <= a_d;
      c_q       <= c_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
      seq_err_q <= seq_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign C_out   = c_q;
  assign ovf     = ovf_q;
  assign busy    = mul_busy;
  assign seq_err = seq_err_q;
  assign ovr     = ovr_q;

endmodule
